// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache between the MEM
//   stage and a 256-bit-wide off-chip data memory.  Hits complete in the
//   request cycle; misses raise p1_stall_o until the victim line has been
//   written back (if dirty) and the requested line has been refilled.  The
//   retried access then hits.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active low
//   p1_req_i       MEM-stage access valid
//   p1_write_i     1 = store, 0 = load
//   p1_addr_i      byte address (word aligned, bits [1:0] ignored)
//   p1_data_i      store data
//   p1_data_o      load data (0 unless a load hits)
//   p1_stall_o     pipeline freeze request
//   mem_enable_o   memory request valid
//   mem_write_o    1 = line write-back, 0 = line read
//   mem_addr_o     line address (low 5 bits zero)
//   mem_data_o     write-back line
//   mem_data_i     refill line
//   mem_ack_i      one-cycle completion pulse
// ---------------------------------------------------------------------------
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 p1_req_i,
   input  logic                 p1_write_i,
   input  logic [31:0]          p1_addr_i,
   input  logic [31:0]          p1_data_i,
   output logic [31:0]          p1_data_o,
   output logic                 p1_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int OFF_W = $clog2(LINE_BITS / 8);
   localparam int TAG_W = 32 - IDX_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t               state;
   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_BITS-1:0] data_mem [NUM_LINES];

   // Line address of the access that missed; the refill targets this even
   // if the CPU drops its request part-way through the miss.
   logic [31:0]          miss_addr;

   logic                 mem_enable_q;
   logic                 mem_write_q;
   logic [31:0]          mem_addr_q;
   logic [LINE_BITS-1:0] mem_data_q;

   // Address decomposition
   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [2:0]           req_word;
   logic [TAG_W-1:0]     miss_tag;
   logic [IDX_W-1:0]     miss_idx;
   logic [LINE_BITS-1:0] rd_line;
   logic [31:0]          rd_word;
   logic                 hit;
   logic                 victim_dirty;
   logic                 unused_addr_bits;

   assign req_tag          = p1_addr_i[31 -: TAG_W];
   assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
   assign req_word         = p1_addr_i[4:2];
   assign miss_tag         = miss_addr[31 -: TAG_W];
   assign miss_idx         = miss_addr[OFF_W +: IDX_W];
   assign unused_addr_bits = ^{p1_addr_i[1:0], miss_addr[OFF_W-1:0]};

   assign rd_line      = data_mem[req_idx];
   assign rd_word      = rd_line[{req_word, 5'd0} +: 32];
   assign hit          = p1_req_i & valid[req_idx] & (tag_mem[req_idx] == req_tag);
   assign victim_dirty = valid[req_idx] & dirty[req_idx];

   // CPU side is combinational so a hit costs no extra cycle and a miss
   // stalls in the very cycle it is presented.
   assign p1_data_o  = (rst_i && state == IDLE && hit && !p1_write_i) ? rd_word : 32'd0;
   assign p1_stall_o = rst_i & ((state != IDLE) | (p1_req_i & ~hit));

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   // Control FSM with registered memory-side outputs.  The request fields
   // are loaded on the transition into each memory state and held until
   // its ack, which keeps them stable for the memory.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         valid        <= '0;
         dirty        <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p1_req_i) begin
                  if (hit) begin
                     if (p1_write_i) dirty[req_idx] <= 1'b1;
                  end else if (victim_dirty) begin
                     state        <= WRITEBACK;
                     mem_enable_q <= 1'b1;
                     mem_write_q  <= 1'b1;
                     mem_addr_q   <= {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
                     mem_data_q   <= data_mem[req_idx];
                  end else begin
                     state        <= REFILL;
                     mem_enable_q <= 1'b1;
                     mem_write_q  <= 1'b0;
                     mem_addr_q   <= {req_tag, req_idx, {OFF_W{1'b0}}};
                     mem_data_q   <= '0;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state       <= REFILL;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
                  mem_data_q  <= '0;
               end
            end
            REFILL: begin
               if (mem_ack_i) begin
                  state           <= IDLE;
                  valid[miss_idx] <= 1'b1;
                  dirty[miss_idx] <= 1'b0;
                  mem_enable_q    <= 1'b0;
                  mem_addr_q      <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Miss address capture; only meaningful while a miss is being serviced.
   always_ff @(posedge clk_i) begin
      if (state == IDLE && p1_req_i && !hit) begin
         miss_addr <= {p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
      end
   end

   // Tag and data arrays.  No reset: a line is only ever read once its
   // valid bit is set, and valid is cleared by reset.
   always_ff @(posedge clk_i) begin
      if (state == REFILL && mem_ack_i) begin
         data_mem[miss_idx] <= mem_data_i;
         tag_mem[miss_idx]  <= miss_tag;
      end else if (state == IDLE && hit && p1_write_i) begin
         data_mem[req_idx][{req_word, 5'd0} +: 32] <= p1_data_i;
      end
   end

endmodule
